uart_mat_sequencer: RTL and testbench

UART_MAT_SEQUENCER -- requirements
Module: uart_mat_sequencer

---
 rtl/uart_mat_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_uart_mat_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mat_sequencer.sv
// Frames bytes from a UART receiver into a 2x2 matrix multiplier and streams the
// four 16-bit results back out through the transmitter, MSB first.
module uart_mat_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic        bclk_x8,
    input  logic        rst,
    input  logic        rx_status,
    input  logic [7:0]  rx_byte,
    input  logic        tx_status,
    output logic        tx_ready,
    output logic [7:0]  tx_byte,
    output logic        mat_wr_en,
    output logic [2:0]  mat_wr_addr,
    output logic [7:0]  mat_wr_data,
    output logic        mult_start,
    input  logic        mult_done,
    output logic [1:0]  res_addr,
    input  logic [15:0] res_data,
    output logic        busy,
    output logic        err,
    output logic        ovr
);

    localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        StIdle, StLoad, StMstart, StMwait, StFetch, StTxreq, StTxack, StTxbusy
    } state_e;

    state_e        state_q, state_d;
    logic          rx_prev_q;
    logic          tx_meta_q, tx_sync_q;
    logic [2:0]    idx_q, idx_d;
    logic [2:0]    out_idx_q, out_idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          fetch_wait_q, fetch_wait_d;
    logic [15:0]   res_word_q, res_word_d;
    logic          tx_ready_q, tx_ready_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          wr_en_q, wr_en_d;
    logic [2:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [1:0]    res_addr_q, res_addr_d;
    logic          err_q, err_d;
    logic          ovr_q, ovr_d;
    logic          byte_ev;
    logic [2:0]    out_next;

    // Falling edge of the receiver busy flag marks a completed byte.
    assign byte_ev  = rx_prev_q & ~rx_status;
    assign out_next = out_idx_q + 3'd1;

    always_ff @(posedge bclk_x8 or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            rx_prev_q    <= 1'b0;
            tx_meta_q    <= 1'b0;
            tx_sync_q    <= 1'b0;
            idx_q        <= 3'd0;
            out_idx_q    <= 3'd0;
            timer_q      <= '0;
            fetch_wait_q <= 1'b0;
            res_word_q   <= 16'd0;
            tx_ready_q   <= 1'b0;
            tx_byte_q    <= 8'd0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= 3'd0;
            wr_data_q    <= 8'd0;
            res_addr_q   <= 2'd0;
            err_q        <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_prev_q    <= rx_status;
            tx_meta_q    <= tx_status;
            tx_sync_q    <= tx_meta_q;
            idx_q        <= idx_d;
            out_idx_q    <= out_idx_d;
            timer_q      <= timer_d;
            fetch_wait_q <= fetch_wait_d;
            res_word_q   <= res_word_d;
            tx_ready_q   <= tx_ready_d;
            tx_byte_q    <= tx_byte_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            res_addr_q   <= res_addr_d;
            err_q        <= err_d;
            ovr_q        <= ovr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        out_idx_d    = out_idx_q;
        timer_d      = timer_q;
        fetch_wait_d = fetch_wait_q;
        res_word_d   = res_word_q;
        tx_ready_d   = tx_ready_q;
        tx_byte_d    = tx_byte_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        res_addr_d   = res_addr_q;
        err_d        = 1'b0;
        ovr_d        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (byte_ev && (rx_byte == SYNC_BYTE)) begin
                    state_d = StLoad;
                    idx_d   = 3'd0;
                    timer_d = '0;
                end
            end
            StLoad: begin
                if (byte_ev) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = rx_byte;
                    idx_d     = idx_q + 3'd1;
                    timer_d   = '0;
                    if (idx_q == 3'd7) state_d = StMstart;
                end else if (timer_q == TimerLast) begin
                    err_d   = 1'b1;
                    timer_d = '0;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StMstart: state_d = StMwait;
            StMwait: begin
                if (mult_done) begin
                    state_d      = StFetch;
                    out_idx_d    = 3'd0;
                    res_addr_d   = 2'd0;
                    fetch_wait_d = 1'b0;
                end
            end
            StFetch: begin
                // res_data lags res_addr by a cycle; latch on the second FETCH cycle.
                if (!fetch_wait_q) begin
                    fetch_wait_d = 1'b1;
                end else begin
                    res_word_d = res_data;
                    state_d    = StTxreq;
                end
            end
            StTxreq: begin
                tx_ready_d = 1'b1;
                tx_byte_d  = out_idx_q[0] ? res_word_q[7:0] : res_word_q[15:8];
                state_d    = StTxack;
            end
            StTxack: begin
                if (tx_sync_q) begin
                    tx_ready_d = 1'b0;
                    state_d    = StTxbusy;
                end
            end
            StTxbusy: begin
                if (!tx_sync_q) begin
                    if (out_idx_q == 3'd7) begin
                        state_d = StIdle;
                    end else begin
                        out_idx_d = out_next;
                        if (!out_next[0]) begin
                            state_d      = StFetch;
                            res_addr_d   = out_next[2:1];
                            fetch_wait_d = 1'b0;
                        end else begin
                            state_d = StTxreq;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (byte_ev && !(state_q inside {StIdle, StLoad})) ovr_d = 1'b1;
    end

    assign tx_ready    = tx_ready_q;
    assign tx_byte     = tx_byte_q;
    assign mat_wr_en   = wr_en_q;
    assign mat_wr_addr = wr_addr_q;
    assign mat_wr_data = wr_data_q;
    assign mult_start  = (state_q == StMstart);
    assign res_addr    = res_addr_q;
    assign busy        = (state_q != StIdle);
    assign err         = err_q;
    assign ovr         = ovr_q;

endmodule

// File: tb/tb_uart_mat_sequencer.sv
// Bench for uart_mat_sequencer: receiver driver, multiplier and transmitter models,
// table vectors, hand-written corner sequences and randomized frames.
module tb_uart_mat_sequencer;

    localparam int unsigned TO = 64;

    logic        bclk_x8 = 1'b0;
    logic        rst;
    logic        rx_status;
    logic [7:0]  rx_byte;
    logic        tx_status;
    logic        tx_ready;
    logic [7:0]  tx_byte;
    logic        mat_wr_en;
    logic [2:0]  mat_wr_addr;
    logic [7:0]  mat_wr_data;
    logic        mult_start;
    logic        mult_done;
    logic [1:0]  res_addr;
    logic [15:0] res_data;
    logic        busy;
    logic        err;
    logic        ovr;

    uart_mat_sequencer #(.TIMEOUT_CYC(TO), .SYNC_BYTE(8'hA5)) dut (
        .bclk_x8     (bclk_x8),
        .rst         (rst),
        .rx_status   (rx_status),
        .rx_byte     (rx_byte),
        .tx_status   (tx_status),
        .tx_ready    (tx_ready),
        .tx_byte     (tx_byte),
        .mat_wr_en   (mat_wr_en),
        .mat_wr_addr (mat_wr_addr),
        .mat_wr_data (mat_wr_data),
        .mult_start  (mult_start),
        .mult_done   (mult_done),
        .res_addr    (res_addr),
        .res_data    (res_data),
        .busy        (busy),
        .err         (err),
        .ovr         (ovr)
    );

    always #5 bclk_x8 = ~bclk_x8;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: C = A * B over 8-bit operands, results truncated to 16 bits.
    function automatic void matmul(input logic [7:0] o[8], output logic [15:0] c[4]);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 2; k++) begin
                int s = 0;
                for (int j = 0; j < 2; j++) s += int'(o[r*2+j]) * int'(o[4+j*2+k]);
                c[r*2+k] = s[15:0];
            end
    endfunction

    function automatic void ref_tx(input logic [7:0] o[8], output logic [7:0] t[8]);
        logic [15:0] c[4];
        matmul(o, c);
        for (int i = 0; i < 8; i++) t[i] = (i % 2 == 0) ? c[i/2][15:8] : c[i/2][7:0];
    endfunction

    // Shared model state and event logs.
    logic [7:0]  opnd[8];
    logic [15:0] c_mat[4];
    logic [1:0]  addr_prev;
    logic        ready_prev;
    logic [10:0] wr_log[$];
    logic [7:0]  sent_q[$];
    int mult_dly = 3;
    int mult_cnt = 0;
    int tx_dly   = 2;
    int err_cnt, ovr_cnt, start_cnt, req_cnt;

    // Monitor plus multiplier model (result valid one cycle after res_addr changes).
    initial begin
        mult_done = 1'b0; res_data = 16'd0; addr_prev = 2'd0; ready_prev = 1'b0;
        for (int i = 0; i < 4; i++) c_mat[i] = 16'd0;
        for (int i = 0; i < 8; i++) opnd[i] = 8'd0;
        forever begin
            @(posedge bclk_x8); #1;
            if (mat_wr_en) begin
                opnd[mat_wr_addr] = mat_wr_data;
                wr_log.push_back({mat_wr_addr, mat_wr_data});
            end
            if (err) err_cnt++;
            if (ovr) ovr_cnt++;
            if (tx_ready && !ready_prev) req_cnt++;
            ready_prev = tx_ready;
            mult_done = 1'b0;
            if (mult_cnt > 0) begin
                mult_cnt--;
                if (mult_cnt == 0) mult_done = 1'b1;
            end
            if (mult_start) begin
                start_cnt++;
                matmul(opnd, c_mat);
                mult_cnt = mult_dly;
            end
            res_data  = c_mat[addr_prev];
            addr_prev = res_addr;
        end
    end

    // Transmitter model: delays its busy rise by tx_dly cycles, one byte per request.
    initial begin
        logic [7:0] b;
        tx_status = 1'b0;
        forever begin
            @(posedge bclk_x8); #1;
            if (tx_ready && !rst) begin
                b = tx_byte;
                for (int d = 0; d < tx_dly; d++) begin
                    @(posedge bclk_x8); #1;
                    check("tx_hold_ready", tx_ready, 1);
                    check("tx_hold_byte", tx_byte, b);
                end
                tx_status = 1'b1;
                sent_q.push_back(b);
                for (int h = 0; h < 30 && tx_ready; h++) begin
                    @(posedge bclk_x8); #1;
                end
                check("tx_ready_drop", tx_ready, 0);
                tx_status = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge bclk_x8); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_byte = b;
        rx_status = 1'b1;
        tick(2);
        rx_status = 1'b0;
        tick(1 + gap);
    endtask

    task automatic clear_logs();
        wr_log.delete(); sent_q.delete();
        err_cnt = 0; ovr_cnt = 0; start_cnt = 0; req_cnt = 0;
    endtask

    task automatic send_frame(input logic [7:0] o[8], input int gap_max);
        send_byte(8'hA5, $urandom_range(0, gap_max));
        for (int i = 0; i < 8; i++) send_byte(o[i], $urandom_range(0, gap_max));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {26'd0, tx_ready, mat_wr_en, mult_start, err, ovr, busy}, 0);
        check({tag, "_data"}, {11'd0, tx_byte, mat_wr_addr, mat_wr_data, res_addr}, 0);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] o[8],
                               input logic [7:0] exp[8], input int exp_ovr);
        int n = 0;
        while ((sent_q.size() < 8 || busy) && n < 3000) begin
            tick(1);
            n++;
        end
        check({tag, "_nbytes"}, sent_q.size(), 8);
        check({tag, "_idle"}, busy, 0);
        for (int i = 0; i < 8 && i < sent_q.size(); i++)
            check($sformatf("%s_tx%0d", tag, i), sent_q[i], exp[i]);
        check({tag, "_nwr"}, wr_log.size(), 8);
        for (int i = 0; i < 8 && i < wr_log.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), wr_log[i], {3'(i), o[i]});
        check({tag, "_starts"}, start_cnt, 1);
        check({tag, "_reqs"}, req_cnt, 8);
        check({tag, "_err"}, err_cnt, 0);
        check({tag, "_ovr"}, ovr_cnt, exp_ovr);
    endtask

    typedef struct {
        int         npre;
        logic [7:0] pre[2];
        logic [7:0] op[8];
        int         dly;
        logic [7:0] exp[8];
    } vec_t;

    vec_t       vt[4];
    logic [7:0] nom_op[8];
    logic [7:0] nom_exp[8];

    initial begin
        logic [7:0] rop[8];
        logic [7:0] rexp[8];
        int n;

        nom_op  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        nom_exp = '{8'h00, 8'h13, 8'h00, 8'h16, 8'h00, 8'h2B, 8'h00, 8'h32};
        vt[0].npre = 0; vt[0].pre = '{8'h00, 8'h00}; vt[0].op = nom_op;
        vt[0].dly = 2;  vt[0].exp = nom_exp;
        vt[1].npre = 2; vt[1].pre = '{8'h3C, 8'h7F}; vt[1].op = nom_op;
        vt[1].dly = 0;  vt[1].exp = nom_exp;
        vt[2].npre = 0; vt[2].pre = '{8'h00, 8'h00};
        vt[2].op  = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h02};
        vt[2].dly = 20;
        vt[2].exp = '{8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
        vt[3].npre = 1; vt[3].pre = '{8'h5A, 8'h00};
        vt[3].op  = '{8'h80, 8'h10, 8'h02, 8'h03, 8'h40, 8'h01, 8'h20, 8'hFF};
        vt[3].dly = 5;
        vt[3].exp = '{8'h22, 8'h00, 8'h10, 8'h70, 8'h00, 8'hE0, 8'h02, 8'hFF};

        rst = 1'b1; rx_status = 1'b0; rx_byte = 8'h00;
        clear_logs();
        tick(3);
        check_zero("reset");
        rst = 1'b0;
        tick(2);
        check("reset_idle", busy, 0);

        for (int v = 0; v < 4; v++) begin
            clear_logs();
            tx_dly = vt[v].dly;
            for (int p = 0; p < vt[v].npre; p++) send_byte(vt[v].pre[p], 1);
            if (vt[v].npre > 0) begin
                check($sformatf("vec%0d_junk_busy", v), busy, 0);
                check($sformatf("vec%0d_junk_wr", v), wr_log.size(), 0);
            end
            send_frame(vt[v].op, 2);
            check_frame($sformatf("vec%0d", v), vt[v].op, vt[v].exp, 0);
        end

        // Inter-byte timeout discards the partial frame.
        clear_logs(); tx_dly = 1;
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
        tick(TO - 5);
        check("to_early_err", err_cnt, 0);
        check("to_early_busy", busy, 1);
        tick(10);
        check("to_err", err_cnt, 1);
        check("to_busy", busy, 0);
        check("to_start", start_cnt, 0);
        check("to_nwr", wr_log.size(), 2);
        clear_logs();
        send_frame(nom_op, 3);
        check_frame("to_next", nom_op, nom_exp, 0);

        // Overrun byte during MWAIT.
        clear_logs(); mult_dly = 40;
        send_frame(nom_op, 0);
        n = 0;
        while (start_cnt == 0 && n < 50) begin tick(1); n++; end
        check("ovr_started", start_cnt, 1);
        send_byte(8'h55, 0);
        check("ovr_busy", busy, 1);
        check_frame("ovr", nom_op, nom_exp, 1);
        mult_dly = 3;

        // Reset after the third output byte.
        clear_logs(); tx_dly = 4;
        send_frame(nom_op, 1);
        n = 0;
        while (sent_q.size() < 3 && n < 1000) begin tick(1); n++; end
        check("rstmid_sent3", sent_q.size(), 3);
        rst = 1'b1;
        #1;
        check_zero("rstmid");
        tick(3);
        rst = 1'b0;
        tick(20);
        check("rstmid_nomore", sent_q.size(), 3);
        send_byte(8'h01, 2);
        check("rstmid_nosync", busy, 0);
        check("rstmid_nowr", wr_log.size(), 8);
        clear_logs();
        send_frame(nom_op, 1);
        check_frame("rstmid_next", nom_op, nom_exp, 0);

        // Randomized frames against the reference model.
        for (int f = 0; f < 6; f++) begin
            clear_logs();
            tx_dly   = $urandom_range(0, 6);
            mult_dly = $urandom_range(1, 8);
            for (int i = 0; i < 8; i++) rop[i] = 8'($urandom_range(0, 255));
            if (f == 2) rop[3] = 8'hA5;
            n = $urandom_range(0, 2);
            for (int p = 0; p < n; p++) begin
                logic [7:0] jb = 8'($urandom_range(0, 255));
                if (jb == 8'hA5) jb = 8'hA4;
                send_byte(jb, $urandom_range(0, 3));
            end
            send_frame(rop, 6);
            ref_tx(rop, rexp);
            check_frame($sformatf("rnd%0d", f), rop, rexp, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
